// File: rtl/xt_keycode_buffer.sv
// xt_keycode_buffer
// Buffers XT keycodes from the PS/2-to-XT converter and presents them to the
// PC-XT side as port 60h data and IRQ1. It follows the port 61h protocol:
// bit 7 acknowledges the current byte, and bit 6 gates the keyboard clock.
// Holding bit 6 low for long enough requests a keyboard reset, which answers
// with 8'hAA.
//
// Ports:
//   clock, reset     single clock domain, synchronous active-high reset
//   in_irq           upstream keycode valid (level, held until cleared)
//   in_keycode       upstream XT keycode
//   clear_keycode    one-cycle acknowledge pulse back to the upstream block
//   kb_clock_enable  port 61h bit 6 (1 = keyboard clock enabled)
//   kb_clear         port 61h bit 7 (1 = clear/acknowledge)
//   irq1             interrupt request to 8259 IR1
//   port_a_keycode   port 60h read data
//   fifo_count       current FIFO occupancy
//   overrun          sticky flag, set whenever a keycode was dropped
module xt_keycode_buffer #(
    parameter int          DEPTH             = 8,
    parameter logic [15:0] RESET_HOLD_CYCLES = 16'd20000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_irq,
    input  logic [7:0]               in_keycode,
    output logic                     clear_keycode,
    input  logic                     kb_clock_enable,
    input  logic                     kb_clear,
    output logic                     irq1,
    output logic [7:0]               port_a_keycode,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, ACKED = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic            defer_valid_q, defer_valid_d;
    logic [7:0]      defer_code_q, defer_code_d;
    logic [15:0]     hold_q, hold_d;
    logic            clear_q, clear_d;
    logic            irq1_q, irq1_d;
    logic [7:0]      port_q, port_d;

    logic            capture_s, pop_s, push_s, space_s, soft_reset_s, wr_en_s;
    logic [PW-1:0]   wr_addr_s;
    logic [7:0]      wr_data_s, head_s;

    assign capture_s    = in_irq && !clear_q;
    assign pop_s        = (state_q == PRESENT) && kb_clear && kb_clock_enable;
    assign space_s      = (count_q != FULL_C) || pop_s;
    assign soft_reset_s = kb_clock_enable && (hold_q == RESET_HOLD_CYCLES);
    assign head_s       = mem_q[rd_ptr_q];

    // Keyboard-reset hold counter: counts low cycles of the clock enable, saturating.
    always_comb begin
        hold_d = hold_q;
        if (kb_clock_enable) begin
            hold_d = 16'd0;
        end else if (hold_q != RESET_HOLD_CYCLES) begin
            hold_d = hold_q + 16'd1;
        end else begin
            hold_d = hold_q;
        end
    end

    // FIFO write/pointer/flag next state. A pending 8'hFF always goes in before
    // any new keycode; a keycode arriving in the same cycle is deferred one cycle.
    always_comb begin
        push_s        = 1'b0;
        wr_data_s     = in_keycode;
        wr_addr_s     = wr_ptr_q;
        wr_en_s       = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        defer_valid_d = 1'b0;
        defer_code_d  = defer_code_q;
        clear_d       = capture_s;
        if (soft_reset_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = {PW{1'b0}};
            wr_data_s = 8'hAA;
            wr_ptr_d  = PW'(1);
            rd_ptr_d  = {PW{1'b0}};
            count_d   = CW'(1);
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (!kb_clock_enable) begin
                push_s = 1'b0;
            end else if (defer_valid_q) begin
                if (space_s) begin
                    push_s    = 1'b1;
                    wr_data_s = defer_code_q;
                end else begin
                    overrun_d = 1'b1;
                    pending_d = 1'b1;
                end
            end else if (pending_q && space_s) begin
                push_s    = 1'b1;
                wr_data_s = 8'hFF;
                pending_d = 1'b0;
                if (capture_s) begin
                    defer_valid_d = 1'b1;
                    defer_code_d  = in_keycode;
                end else begin
                    defer_valid_d = 1'b0;
                end
            end else if (capture_s) begin
                if (space_s) begin
                    push_s = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                    pending_d = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
            wr_en_s = push_s;
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Output FSM next state and registered port 60h / IRQ1 values.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (kb_clock_enable && !kb_clear && (count_q != {CW{1'b0}}) && !soft_reset_s) begin
                    state_d = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (!kb_clock_enable) begin
                    state_d = IDLE;
                end else if (kb_clear) begin
                    state_d = ACKED;
                end else begin
                    state_d = PRESENT;
                end
            end
            ACKED: begin
                if (!kb_clock_enable || !kb_clear) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACKED;
                end
            end
            default: state_d = IDLE;
        endcase
        irq1_d = (state_d == PRESENT);
        if (irq1_d) begin
            port_d = head_s;
        end else begin
            port_d = 8'h00;
        end
    end

    // State, pointer, flag and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            defer_valid_q <= 1'b0;
            defer_code_q  <= 8'h00;
            hold_q        <= 16'd0;
            clear_q       <= 1'b0;
            irq1_q        <= 1'b0;
            port_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            defer_valid_q <= defer_valid_d;
            defer_code_q  <= defer_code_d;
            hold_q        <= hold_d;
            clear_q       <= clear_d;
            irq1_q        <= irq1_d;
            port_q        <= port_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign clear_keycode  = clear_q;
    assign irq1           = irq1_q;
    assign port_a_keycode = port_q;
    assign fifo_count     = count_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_xt_keycode_buffer.sv
module tb_xt_keycode_buffer;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_irq;
    logic [7:0] in_keycode;
    logic       clear_keycode;
    logic       kb_clock_enable;
    logic       kb_clear;
    logic       irq1;
    logic [7:0] port_a_keycode;
    logic [3:0] fifo_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: the byte stream the XT side should see, plus flags.
    byte unsigned mq[$];
    bit           m_over;
    bit           m_pend;

    xt_keycode_buffer #(.DEPTH(8), .RESET_HOLD_CYCLES(16'd16)) dut (
        .clock(clock), .reset(reset), .in_irq(in_irq), .in_keycode(in_keycode),
        .clear_keycode(clear_keycode), .kb_clock_enable(kb_clock_enable),
        .kb_clear(kb_clear), .irq1(irq1), .port_a_keycode(port_a_keycode),
        .fifo_count(fifo_count), .overrun(overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one accepted keycode while no pop happens in the same cycle.
    task automatic m_capture(input byte unsigned c);
        if (m_pend) begin
            if (mq.size() < 8) begin
                mq.push_back(8'hFF);
                m_pend = 1'b0;
                if (mq.size() < 8) mq.push_back(c);
                else begin m_over = 1'b1; m_pend = 1'b1; end
            end else begin
                m_over = 1'b1;
            end
        end else if (mq.size() < 8) begin
            mq.push_back(c);
        end else begin
            m_over = 1'b1;
            m_pend = 1'b1;
        end
    endtask

    task automatic m_pop();
        void'(mq.pop_front());
        if (m_pend) begin
            mq.push_back(8'hFF);
            m_pend = 1'b0;
        end
    endtask

    task automatic send_key(input byte unsigned c);
        in_irq = 1'b1;
        in_keycode = c;
        @(negedge clock);
        check("clear_pulse_n1", clear_keycode, 1'b1);
        m_capture(c);
        in_irq = 1'b0;
        @(negedge clock);
        check("clear_low_n2", clear_keycode, 1'b0);
        check("count_after_send", 16'(fifo_count), 16'(mq.size()));
        check("overrun_after_send", overrun, m_over);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (irq1 !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("irq1_wait", irq1, 1'b1);
    endtask

    task automatic ack();
        wait_irq();
        check("port60_head", port_a_keycode, mq[0]);
        kb_clear = 1'b1;
        @(negedge clock);
        m_pop();
        check("irq1_after_ack", irq1, 1'b0);
        check("port60_after_ack", port_a_keycode, 8'h00);
        check("count_after_ack", 16'(fifo_count), 16'(mq.size()));
        kb_clear = 1'b0;
        @(negedge clock);
        check("irq1_gap", irq1, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            ack();
            guard++;
        end
        check("drained_count", 16'(fifo_count), 16'd0);
    endtask

    task automatic clock_low(input int len);
        kb_clock_enable = 1'b0;
        repeat (len) begin
            @(negedge clock);
            check("irq1_while_disabled", irq1, 1'b0);
        end
        kb_clock_enable = 1'b1;
        if (len >= 16) begin
            mq.delete();
            mq.push_back(8'hAA);
            m_over = 1'b0;
            m_pend = 1'b0;
        end
        @(negedge clock);
        wait_irq();
        check("port60_after_low", port_a_keycode, mq[0]);
        check("count_after_low", 16'(fifo_count), 16'(mq.size()));
        check("overrun_after_low", overrun, m_over);
    endtask

    initial begin
        reset = 1'b1;
        in_irq = 1'b0;
        in_keycode = 8'h00;
        kb_clock_enable = 1'b1;
        kb_clear = 1'b0;
        m_over = 1'b0;
        m_pend = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_clear", clear_keycode, 1'b0);
        check("rst_irq1", irq1, 1'b0);
        check("rst_port60", port_a_keycode, 8'h00);
        check("rst_count", 16'(fifo_count), 16'd0);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Single key
        send_key(8'h1E);
        check("single_irq1_n2", irq1, 1'b1);
        check("single_port60", port_a_keycode, 8'h1E);
        ack();
        check("single_count0", 16'(fifo_count), 16'd0);

        // Burst and ordering
        send_key(8'h1E);
        send_key(8'h9E);
        send_key(8'h30);
        check("burst_count3", 16'(fifo_count), 16'd3);
        drain();

        // Overflow: ten codes into eight slots
        for (int i = 1; i <= 10; i++) send_key(8'(i));
        check("ovf_count8", 16'(fifo_count), 16'd8);
        check("ovf_overrun", overrun, 1'b1);
        ack();
        check("ovf_ff_count", 16'(fifo_count), 16'd8);
        check("ovf_tail_ff", 16'(mq[7]), 16'h00FF);
        drain();
        check("ovf_sticky", overrun, 1'b1);

        // Soft reset: long low pulse flushes and returns 8'hAA
        send_key(8'h10);
        send_key(8'h11);
        send_key(8'h12);
        clock_low(16);
        check("soft_only_aa", 16'(mq.size()), 16'd1);
        drain();

        // Short low pulse keeps contents
        send_key(8'h21);
        send_key(8'h22);
        send_key(8'h23);
        clock_low(15);
        check("short_kept", 16'(fifo_count), 16'd3);
        drain();

        // Full FIFO with pop and capture in the same cycle
        for (int i = 0; i < 8; i++) send_key(8'(8'h40 + i));
        wait_irq();
        check("full_head", port_a_keycode, mq[0]);
        kb_clear = 1'b1;
        in_irq = 1'b1;
        in_keycode = 8'h55;
        @(negedge clock);
        void'(mq.pop_front());
        mq.push_back(8'h55);
        check("simul_clear", clear_keycode, 1'b1);
        check("simul_count8", 16'(fifo_count), 16'd8);
        check("simul_overrun0", overrun, 1'b0);
        in_irq = 1'b0;
        kb_clear = 1'b0;
        @(negedge clock);
        drain();
        check("simul_overrun_end", overrun, 1'b0);

        // Randomized bursts and partial acknowledges
        for (int r = 0; r < 12; r++) begin
            int nb = $urandom_range(1, 5);
            int na;
            for (int k = 0; k < nb; k++) send_key(8'($urandom));
            na = $urandom_range(0, mq.size());
            for (int k = 0; k < na; k++) ack();
        end
        drain();

        // Reset while presenting with clear_keycode in flight
        send_key(8'h2C);
        wait_irq();
        in_irq = 1'b1;
        in_keycode = 8'h2D;
        @(negedge clock);
        check("mid_clear_high", clear_keycode, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        in_irq = 1'b0;
        mq.delete();
        m_over = 1'b0;
        m_pend = 1'b0;
        check("mid_rst_clear", clear_keycode, 1'b0);
        check("mid_rst_irq1", irq1, 1'b0);
        check("mid_rst_port60", port_a_keycode, 8'h00);
        check("mid_rst_count", 16'(fifo_count), 16'd0);
        check("mid_rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_idle", irq1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xt_keycode_buffer.md
Name: xt_keycode_buffer

Overview:
- Sits directly downstream of the PS/2-to-XT keycode converter. Takes its irq/keycode pair and returns the clear_keycode handshake.
- Buffers keycodes in a FIFO and presents them to the PC-XT side: port 60h data and IRQ1.
- Follows the XT port 61h protocol: bit 7 is the keyboard clear/acknowledge; bit 6 is the keyboard clock enable, used for the soft reset that returns 0xAA.

Parameters:
- DEPTH, 8: FIFO entries. Power of 2, minimum 2.
- RESET_HOLD_CYCLES, 16'd20000: consecutive cycles kb_clock_enable must be low to count as a keyboard reset request.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_irq  in  1  upstream keycode valid; level, held until cleared.
- in_keycode  in  8  upstream XT keycode.
- clear_keycode  out  1  one-cycle pulse to upstream acknowledging capture.
- kb_clock_enable  in  1  port 61h bit 6 (1 = keyboard clock enabled).
- kb_clear  in  1  port 61h bit 7 (1 = clear/acknowledge).
- irq1  out  1  interrupt request to the 8259 IR1.
- port_a_keycode  out  8  port 60h read data.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overrun  out  1  sticky; set on dropped keycode, cleared by reset or soft reset.

Behaviour:
- Reset: FIFO empty; clear_keycode=0, irq1=0, port_a_keycode=8'h00, fifo_count=0, overrun=0, hold counter=0; output FSM in IDLE.

Capture:
- Capture happens when in_irq=1 and clear_keycode=0 in cycle N.
- clear_keycode=1 in cycle N+1 and is always 0 in N+2. in_irq is ignored while clear_keycode=1, so there is no double capture.
- Push at the cycle-N edge if not full, or if a pop occurs in the same cycle (pop has priority; the slot is reused).
- If full with no pop: the keycode is dropped, overrun is set, and a pending_ff flag is set.
- While pending_ff=1 and there is space: push 8'hFF (XT overrun code) before any new keycode, then clear pending_ff. If a capture arrives in the same cycle, 8'hFF goes first and the keycode is pushed the next cycle; if there is no space for it, the keycode is dropped.
- While kb_clock_enable=0: captures are still acknowledged but discarded; no push.

Output FSM (IDLE, PRESENT, ACKED):
- IDLE: irq1=0, port_a_keycode=8'h00. Go to PRESENT the cycle after FIFO non-empty && kb_clear=0 && kb_clock_enable=1.
- PRESENT: irq1=1, port_a_keycode=head (registered, stable). On kb_clear=1: pop head, irq1=0, port_a_keycode=8'h00, go to ACKED.
- ACKED: hold irq1=0 until kb_clear=0, then go to IDLE. Next entry is presented one cycle later, so the minimum gap with irq1 low is 2 cycles after kb_clear falls.
- kb_clock_enable=0 in any state: go to IDLE, irq1=0, no pop.

Soft reset:
- hold counter increments while kb_clock_enable=0, saturating at RESET_HOLD_CYCLES; it clears to 0 when kb_clock_enable=1.
- On the cycle kb_clock_enable rises with counter==RESET_HOLD_CYCLES: flush FIFO, clear overrun and pending_ff, push 8'hAA.
- A shorter low pulse only suppresses irq1; FIFO contents are kept.

General:
- fifo_count reflects pushes and pops with 1-cycle latency (registered).
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
- A reset asserted mid-handshake overrides everything in the same edge, including a clear_keycode pulse in flight.

Test Plan:
- Single key: in_irq=1 with in_keycode=8'h1E, held until clear_keycode → clear_keycode pulses one cycle at N+1; fifo_count=1; irq1=1 and port_a_keycode=8'h1E by N+3; kb_clear pulse → irq1=0, data 8'h00, fifo_count=0.
- Burst and ordering: send 8'h1E, 8'h9E, 8'h30 with no acks → fifo_count=3; three kb_clear pulses → port 60h yields 1E, 9E, 30 in order; irq1 low for ≥2 cycles between entries.
- Overflow (DEPTH=8): push 10 codes without acks → fifo_count=8; overrun=1; codes 9 and 10 dropped. One ack → the next entry written is 8'hFF, behind the 7 remaining originals.
- Full with simultaneous pop: FIFO full and kb_clear rising in the same cycle as a capture → pop and push both succeed; fifo_count stays 8; overrun stays 0.
- Soft reset (RESET_HOLD_CYCLES=16): kb_clock_enable low 16 cycles then high, with 3 entries queued → FIFO flushed; only 8'hAA is presented with irq1=1; overrun=0. A low pulse of 15 cycles → the 3 entries are kept and no 8'hAA appears.
- Reset mid-handshake: assert reset while in PRESENT with clear_keycode high → next cycle all outputs are at reset values and fifo_count=0.
